// File: rtl/fp32_divider_seq.sv
// Iterative IEEE-754 single-precision divider: restoring mantissa division,
// RADIX_BITS quotient bits per clock, round-to-nearest-even, flush-to-zero.
module fp32_divider_seq #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam int STEPS = 26 / RADIX_BITS;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] ROUND  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  state;
  logic        sign;
  logic [9:0]  exp_r;
  logic [23:0] div_mb;
  logic [24:0] rem;
  logic [25:0] quo;
  logic [4:0]  count;

  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, in_sign;
  logic        special;
  logic [31:0] spec_result;
  logic [3:0]  spec_flags;

  assign in_ready = (state == IDLE);
  assign in_sign  = a[31] ^ b[31];

  // Denormals have a zero exponent field, so they classify as zero here.
  assign a_zero = (a[30:23] == 8'h00);
  assign b_zero = (b[30:23] == 8'h00);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

  always_comb begin
    special     = 1'b1;
    spec_result = 32'd0;
    spec_flags  = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result = {in_sign, 8'hFF, 23'h400000};
      spec_flags  = 4'b1000;
    end else if (a_inf) begin
      spec_result = {in_sign, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_result = {in_sign, 8'hFF, 23'd0};
      spec_flags  = 4'b0100;
    end else if (a_zero || b_inf) begin
      spec_result = {in_sign, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  logic [24:0] rem_step;
  logic [25:0] quo_step;

  // The partial remainder is kept pre-shifted for the next quotient bit.
  always_comb begin
    rem_step = rem;
    quo_step = quo;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (rem_step >= {1'b0, div_mb}) begin
        rem_step = rem_step - {1'b0, div_mb};
        quo_step = {quo_step[24:0], 1'b1};
      end else begin
        quo_step = {quo_step[24:0], 1'b0};
      end
      rem_step = {rem_step[23:0], 1'b0};
    end
  end

  logic [23:0] mant_t;
  logic [24:0] mant_r;
  logic [22:0] frac;
  logic        guard, sticky, round_up;
  logic [9:0]  e_adj, e_fin;
  logic [31:0] round_result;
  logic [3:0]  round_flags;

  always_comb begin
    if (quo[25]) begin
      mant_t = quo[25:2];
      guard  = quo[1];
      sticky = quo[0] | (|rem);
      e_adj  = exp_r;
    end else begin
      mant_t = quo[24:1];
      guard  = quo[0];
      sticky = |rem;
      e_adj  = exp_r - 10'd1;
    end
    round_up = guard & (sticky | mant_t[0]);
    mant_r   = {1'b0, mant_t} + {24'd0, round_up};
    if (mant_r[24]) begin
      frac  = mant_r[23:1];
      e_fin = e_adj + 10'd1;
    end else begin
      frac  = mant_r[22:0];
      e_fin = e_adj;
    end
    round_flags = 4'b0000;
    if ($signed(e_fin) >= 10'sd255) begin
      round_result = {sign, 8'hFF, 23'd0};
      round_flags  = 4'b0010;
    end else if ($signed(e_fin) <= 10'sd0) begin
      round_result = {sign, 31'd0};
      round_flags  = 4'b0001;
    end else begin
      round_result = {sign, e_fin[7:0], frac};
    end
  end

  // out_valid rises one cycle after DONE is entered and holds until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sign      <= 1'b0;
      exp_r     <= 10'd0;
      div_mb    <= 24'd0;
      rem       <= 25'd0;
      quo       <= 26'd0;
      count     <= 5'd0;
      result    <= 32'd0;
      flags     <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_sign;
            if (special) begin
              result <= spec_result;
              flags  <= spec_flags;
              state  <= DONE;
            end else begin
              exp_r  <= {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
              div_mb <= {1'b1, b[22:0]};
              rem    <= {2'b01, a[22:0]};
              quo    <= 26'd0;
              count  <= 5'd0;
              state  <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count + 5'd1;
          if (count == 5'(STEPS - 1)) state <= ROUND;
        end
        ROUND: begin
          result <= round_result;
          flags  <= round_flags;
          state  <= DONE;
        end
        default: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider_seq.sv
// Directed scoreboard bench for fp32_divider_seq: normal, special, range,
// backpressure and mid-operation reset cases.
module tb_fp32_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   accept_cycle = 0;

  fp32_divider_seq #(.RADIX_BITS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; accept_cycle is read after the accept edge.
  task automatic applyStimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] res, input logic [3:0] flg, input int lat);
    int n;
    sb.push_back('{tag, res, flg, lat});
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
    if (in_ready === 1'b1) begin
      @(posedge clk);
      @(negedge clk);
    end
    accept_cycle = cycle;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput();
    int   n;
    exp_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkVal("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    if (out_valid !== 1'b1) return;
    checkVal("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkVal({e.tag, "_result"}, result, e.res);
    checkVal({e.tag, "_flags"}, {28'd0, flags}, {28'd0, e.flg});
    checkVal({e.tag, "_latency"}, 32'(cycle - accept_cycle), 32'(e.lat));
    if (out_ready) begin
      @(negedge clk);
      checkVal({e.tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      checkVal({e.tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    int n;
    int stray;
    #1;
    checkVal("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("reset_result", result, 32'd0);
    checkVal("reset_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("div6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28); checkOutput();
    applyStimulus("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28); checkOutput();
    applyStimulus("neg", 32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28); checkOutput();
    applyStimulus("one_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28); checkOutput();

    // Special operands resolve at accept; invalid results carry the computed sign.
    applyStimulus("x_div0", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1); checkOutput();
    applyStimulus("z_div_nz", 32'h00000000, 32'h80000000, 32'hFFC00000, 4'b1000, 1); checkOutput();
    applyStimulus("inf_div_x", 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000, 1); checkOutput();
    applyStimulus("nan_in", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1); checkOutput();
    applyStimulus("inf_inf", 32'hFF800000, 32'h7F800000, 32'hFFC00000, 4'b1000, 1); checkOutput();
    applyStimulus("x_div_inf", 32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 1); checkOutput();
    applyStimulus("zero_div_x", 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1); checkOutput();

    applyStimulus("ovf", 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28); checkOutput();
    applyStimulus("unf", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28); checkOutput();
    applyStimulus("unf_deep", 32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 28); checkOutput();
    applyStimulus("denorm", 32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1); checkOutput();

    // Backpressure: result must hold while new operands wait at the input.
    out_ready = 1'b0;
    applyStimulus("bp", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) void'(sb.pop_front());
    checkVal("bp_latency", 32'(cycle - accept_cycle), 32'd28);
    a = 32'h3F800000;
    b = 32'h40400000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkVal("bp_result_hold", result, 32'h40400000);
      checkVal("bp_flags_hold", {28'd0, flags}, 32'd0);
      checkVal("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      checkVal("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    sb.push_back('{"bp_next", 32'h3EAAAAAB, 4'b0000, 28});
    @(negedge clk);
    checkVal("bp_release_ready", {31'd0, in_ready}, 32'd1);
    checkVal("bp_release_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    accept_cycle = cycle;
    in_valid = 1'b0;
    checkVal("bp_next_busy", {31'd0, in_ready}, 32'd0);
    checkOutput();

    // Reset during DIVIDE aborts the operation with no late result.
    applyStimulus("rst_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkVal("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) stray++;
    end
    checkVal("rst_no_stale", 32'(stray), 32'd0);
    applyStimulus("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28); checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
